// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//
// Converts single read/write commands into AXI4-Lite master transactions, one at a time.
// A command is accepted in IDLE. It is issued on AW+W (write) or AR (read). The completion
// status, plus read data for reads, is then presented on the rsp_* port until it is consumed.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN    clock, synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_wstrb
//   rsp_valid/rsp_ready          response handshake; rsp_rdata (0 for writes), rsp_resp
//   M_AXI_AW*, M_AXI_W*, M_AXI_B*, M_AXI_AR*, M_AXI_R*   AXI4-Lite master channels
//
// Every AXI VALID/READY output comes from a flop. None of them depends combinationally on a
// slave READY.
module axi_lite_cmd_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    // command port
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    // response port
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    // write address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    // write data channel
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    // write response channel
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    // read address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    // read data channel
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int unsigned StrbWidth = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StResp
    } state_e;

    state_e                        state_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [StrbWidth-1:0]          wstrb_q;
    logic                          awvalid_q;
    logic                          wvalid_q;
    logic                          bready_q;
    logic                          arvalid_q;
    logic                          rready_q;
    logic                          rsp_valid_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]                    rsp_resp_q;

    logic aw_fire;
    logic w_fire;

    assign aw_fire = awvalid_q & M_AXI_AWREADY;
    assign w_fire  = wvalid_q & M_AXI_WREADY;

    assign cmd_ready     = (state_q == StIdle);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWrAddrData;
                        end else begin
                            araddr_q  <= cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= StRdAddr;
                        end
                    end
                end
                StWrAddrData: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                    end
                    // A channel whose VALID is already low has completed its handshake earlier.
                    if ((aw_fire || !awvalid_q) && (w_fire || !wvalid_q)) begin
                        bready_q <= 1'b1;
                        state_q  <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (M_AXI_BVALID && bready_q) begin
                        rsp_resp_q  <= M_AXI_BRESP;
                        rsp_rdata_q <= '0;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StRdAddr: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (M_AXI_RVALID && rready_q) begin
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
module tb_axi_lite_cmd_master;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_d;
        int          w_d;
        int          b_d;
        int          ar_d;
        int          r_d;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
    } cmd_t;

    logic        clk;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int errors = 0;
    int checks = 0;

    cmd_t        cmds[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];

    axi_lite_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .M_AXI_AWADDR (AWADDR),
        .M_AXI_AWPROT (AWPROT),
        .M_AXI_AWVALID(AWVALID),
        .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA  (WDATA),
        .M_AXI_WSTRB  (WSTRB),
        .M_AXI_WVALID (WVALID),
        .M_AXI_WREADY (WREADY),
        .M_AXI_BRESP  (BRESP),
        .M_AXI_BVALID (BVALID),
        .M_AXI_BREADY (BREADY),
        .M_AXI_ARADDR (ARADDR),
        .M_AXI_ARPROT (ARPROT),
        .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA  (RDATA),
        .M_AXI_RRESP  (RRESP),
        .M_AXI_RVALID (RVALID),
        .M_AXI_RREADY (RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------------------
    // Slave model: per-command READY/VALID delays, memory built from what the DUT sends.
    // Runs 1 time unit after each falling edge so the command pushes of the same edge are
    // already visible.
    // ---------------------------------------------------------------------------------
    int          sidx = 0;
    bit          have;
    cmd_t        c;
    bit          aw_fired, w_fired, ar_fired, aw_done, w_done, b_pend, b_fired, r_pend, r_fired;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_hi, w_hi, ar_hi;
    logic [31:0] aw_cap, w_cap, ar_cap;
    logic [3:0]  ws_cap;

    initial begin : slave
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
                ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
                {aw_fired, w_fired, ar_fired, aw_done, w_done} = '0;
                {b_pend, b_fired, r_pend, r_fired} = '0;
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_hi, w_hi, ar_hi} = '0;
                sidx = cmds.size();
                continue;
            end
            have = (sidx < cmds.size());
            if (have) c = cmds[sidx];
            // write response
            if (b_fired) begin
                chk("b_ready_drop", BREADY, 0);
                BVALID = 0; b_fired = 0; b_pend = 0; aw_done = 0; w_done = 0; sidx++;
            end else if (b_pend) begin
                if (!BVALID) begin
                    if (b_cnt >= c.b_d) begin BVALID = 1; BRESP = c.resp; end
                    else b_cnt++;
                end
                if (BVALID && BREADY) b_fired = 1;
            end
            // read data
            if (r_fired) begin
                chk("r_ready_drop", RREADY, 0);
                RVALID = 0; r_fired = 0; r_pend = 0; sidx++;
            end else if (r_pend) begin
                if (!RVALID) begin
                    if (r_cnt >= c.r_d) begin
                        RVALID = 1; RRESP = c.resp;
                        RDATA = slv_mem.exists(ar_cap) ? slv_mem[ar_cap] : 32'h0;
                    end else r_cnt++;
                end
                if (RVALID && RREADY) r_fired = 1;
            end
            have = (sidx < cmds.size());
            if (have) c = cmds[sidx];
            // write address
            if (aw_fired) begin
                chk("aw_valid_drop", AWVALID, 0); aw_fired = 0;
            end else if (aw_hi != 0) chk("aw_valid_hold", AWVALID, 1);
            if (AWVALID && have) begin
                aw_hi++;
                if (!AWREADY) begin
                    if (aw_cnt >= c.aw_d) AWREADY = 1; else aw_cnt++;
                end
                if (AWREADY) begin
                    chk("aw_addr", AWADDR, c.addr);
                    chk("aw_prot", AWPROT, 0);
                    chk("aw_valid_cycles", aw_hi, c.aw_d + 1);
                    aw_cap = AWADDR; aw_fired = 1; aw_done = 1; aw_hi = 0; aw_cnt = 0;
                end
            end else if (!AWVALID) AWREADY = have && c.wr && !aw_done && c.aw_d == 0;
            // write data
            if (w_fired) begin
                chk("w_valid_drop", WVALID, 0); w_fired = 0;
            end else if (w_hi != 0) chk("w_valid_hold", WVALID, 1);
            if (WVALID && have) begin
                w_hi++;
                if (!WREADY) begin
                    if (w_cnt >= c.w_d) WREADY = 1; else w_cnt++;
                end
                if (WREADY) begin
                    chk("w_data", WDATA, c.wdata);
                    chk("w_strb", WSTRB, c.strb);
                    chk("w_valid_cycles", w_hi, c.w_d + 1);
                    w_cap = WDATA; ws_cap = WSTRB; w_fired = 1; w_done = 1; w_hi = 0; w_cnt = 0;
                end
            end else if (!WVALID) WREADY = have && c.wr && !w_done && c.w_d == 0;
            if (aw_done && w_done && !b_pend && !b_fired) begin
                slv_mem[aw_cap] = merge(slv_mem.exists(aw_cap) ? slv_mem[aw_cap] : 32'h0,
                                        w_cap, ws_cap);
                b_pend = 1; b_cnt = 0;
            end
            // read address
            if (ar_fired) begin
                chk("ar_valid_drop", ARVALID, 0); ar_fired = 0;
            end else if (ar_hi != 0) chk("ar_valid_hold", ARVALID, 1);
            if (ARVALID && have) begin
                ar_hi++;
                if (!ARREADY) begin
                    if (ar_cnt >= c.ar_d) ARREADY = 1; else ar_cnt++;
                end
                if (ARREADY) begin
                    chk("ar_addr", ARADDR, c.addr);
                    chk("ar_prot", ARPROT, 0);
                    chk("ar_is_read", c.wr, 0);
                    chk("ar_valid_cycles", ar_hi, c.ar_d + 1);
                    ar_cap = ARADDR; ar_fired = 1; r_pend = 1; r_cnt = 0; ar_hi = 0; ar_cnt = 0;
                end
            end else if (!ARVALID) ARREADY = have && !c.wr && !r_pend && c.ar_d == 0;
        end
    end

    // ---------------------------------------------------------------------------------
    // Command driver and reference model
    // ---------------------------------------------------------------------------------
    task automatic start_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int awd, input int wd, input int bd,
                             input int ard, input int rd, input logic [1:0] resp,
                             input bit exp_ready, output int idx);
        cmd_t n;
        @(negedge clk);
        n.wr = wr; n.addr = a; n.wdata = d; n.strb = s;
        n.aw_d = awd; n.w_d = wd; n.b_d = bd; n.ar_d = ard; n.r_d = rd; n.resp = resp;
        if (wr) begin
            n.exp_rdata = 32'h0;
            ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 32'h0, d, s);
        end else begin
            n.exp_rdata = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        end
        idx = cmds.size();
        cmds.push_back(n);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        chk("cmd_ready_at_issue", cmd_ready, exp_ready);
    endtask

    task automatic finish_cmd(input int idx, input int hold, input bit keep);
        int t;
        t = 0;
        @(negedge clk);
        if (!keep) cmd_valid = 0;
        while (!rsp_valid && t < 200) begin
            chk("cmd_ready_busy", cmd_ready, 0);
            if (!keep) begin
                // junk commands while busy must be ignored
                cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
                cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            end
            @(negedge clk);
            t++;
        end
        if (!keep) cmd_valid = 0;
        chk("rsp_valid_timeout", rsp_valid, 1);
        if (!rsp_valid) return;
        for (int i = 0; i < hold; i++) begin
            chk("rsp_hold_rdata", rsp_rdata, cmds[idx].exp_rdata);
            chk("rsp_hold_resp", rsp_resp, cmds[idx].resp);
            chk("rsp_hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
            chk("rsp_hold_valid", rsp_valid, 1);
        end
        chk("rsp_rdata", rsp_rdata, cmds[idx].exp_rdata);
        chk("rsp_resp", rsp_resp, cmds[idx].resp);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_valid_after_hs", rsp_valid, 0);
        chk("cmd_ready_after_hs", cmd_ready, 1);
    endtask

    initial begin : main
        int idx, idx2, t;
        rstn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        repeat (3) @(negedge clk);
        // reset state
        chk("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 6'b0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_awaddr", AWADDR, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_wdata_wstrb", {WDATA, WSTRB}, 0);
        chk("rst_prot", {AWPROT, ARPROT}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rstn = 1;
        @(negedge clk);

        // write 0xFF to 0x960, slave ready immediately
        start_cmd(1, 32'h960, 32'h0000_00FF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 1, idx);
        finish_cmd(idx, 0, 0);
        // AWREADY one cycle late, WREADY four cycles late
        start_cmd(1, 32'h964, 32'hA5A5_1234, 4'h5, 1, 4, 2, 0, 0, 2'b00, 1, idx);
        finish_cmd(idx, 1, 0);
        // read back 0x960
        start_cmd(0, 32'h960, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'b00, 1, idx);
        finish_cmd(idx, 0, 0);
        // SLVERR read held five cycles
        start_cmd(0, 32'h964, 32'h0, 4'h0, 0, 0, 0, 0, 3, 2'b10, 1, idx);
        finish_cmd(idx, 5, 0);

        // reset while waiting for the write response
        start_cmd(1, 32'h300, 32'hDEAD_BEEF, 4'hF, 0, 1, 8, 0, 0, 2'b00, 1, idx);
        t = 0;
        do begin
            @(negedge clk);
            cmd_valid = 0;
            t++;
        end while (!BREADY && t < 50);
        chk("rst_wr_resp_reached", BREADY, 1);
        rstn = 0;
        @(posedge clk);
        #1;
        chk("midrst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, 6'b0);
        chk("midrst_rsp", {rsp_rdata, rsp_resp}, 0);
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("midrst_cmd_ready", cmd_ready, 1);
        repeat (4) @(negedge clk);
        chk("midrst_no_rsp", rsp_valid, 0);

        // back-to-back with cmd_valid held: write then read of the same word
        start_cmd(1, 32'h104, 32'h1357_9BDF, 4'hF, 0, 0, 1, 0, 0, 2'b01, 1, idx);
        start_cmd(0, 32'h104, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, idx2);
        finish_cmd(idx, 2, 1);
        finish_cmd(idx2, 0, 0);
        chk("b2b_read_data", rsp_rdata, 32'h1357_9BDF);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = {22'h0, 2'($urandom_range(0, 3)), 8'h00} + 32'(4 * $urandom_range(0, 1));
            start_cmd(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), 2'($urandom), 1, idx);
            finish_cmd(idx, $urandom_range(0, 3), 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; byte strobe width = C_M_AXI_DATA_WIDTH/8.
REQ-003 SHALL have one clock and a synchronous, active-low reset, named as follows.
REQ-004 M_AXI_ACLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 M_AXI_ARESETN  in  1  synchronous active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_W  byte address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 cmd_wstrb  in  DATA_W/8  write byte strobes.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes.
REQ-015 rsp_resp  out  2  BRESP or RRESP of the completed transaction.
REQ-016 M_AXI_AW{ADDR,PROT,VALID,READY}, M_AXI_W{DATA,STRB,VALID,READY}, M_AXI_B{RESP,VALID,READY}, M_AXI_AR{ADDR,PROT,VALID,READY}, M_AXI_R{DATA,RESP,VALID,READY}: standard AXI4-Lite master ports, widths per parameters.

Function
REQ-017 SHALL have one outstanding transaction max; states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE; combinational from state.
REQ-019 On acceptance in cycle N, the block SHALL register addr/wdata/wstrb and enter WR_ADDR_DATA (write) or RD_ADDR (read); AWVALID+WVALID or ARVALID high from cycle N+1.
REQ-020 AWPROT and ARPROT SHALL be 3'b000 constantly.
REQ-021 In WR_ADDR_DATA, AWVALID and WVALID SHALL each drop the cycle after their own handshake, independently; AW/W payload stable while VALID high.
REQ-022 When both AW and W handshakes completed (same or different cycles), SHALL enter WR_RESP with BREADY=1.
REQ-023 In WR_RESP, on BVALID&&BREADY SHALL capture BRESP into rsp_resp, set rsp_rdata=0, deassert BREADY, enter RESP.
REQ-024 In RD_ADDR, ARVALID SHALL stay high with stable ARADDR until ARREADY; then enter RD_DATA with RREADY=1.
REQ-025 In RD_DATA, on RVALID&&RREADY SHALL capture RDATA/RRESP, deassert RREADY, enter RESP.
REQ-026 In RESP, rsp_valid SHALL be 1 with stable rsp_rdata/rsp_resp until rsp_ready; then IDLE next cycle.
REQ-027 No VALID SHALL depend combinationally on any AXI READY; all AXI VALID/READY outputs registered.
REQ-028 SLVERR/DECERR responses SHALL be passed through unchanged; no retry.
REQ-029 Handshake in the same cycle VALID first rises (READY already high) SHALL complete normally.
REQ-030 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-031 Reset SHALL force IDLE and all outputs low: AW/W/AR VALID, BREADY, RREADY, rsp_valid=0, rsp_rdata=0, rsp_resp=0, AWADDR/ARADDR/WDATA/WSTRB=0.
REQ-032 Reset mid-transaction SHALL abandon it; outputs reach reset values the cycle after reset sampled low; no response issued.

Verification
REQ-033 Write 0x0000_00FF to 0x960, strb 0xF, slave READY immediate -> AWVALID/WVALID one cycle, BREADY until BVALID, rsp_valid with rsp_resp=0, rsp_rdata=0.
REQ-034 Write with AWREADY at cycle+1, WREADY at cycle+4 -> AWVALID drops after cycle+1, WVALID holds until cycle+4, then WR_RESP.
REQ-035 Read 0x960 after REQ-033 write -> ARVALID until ARREADY, rsp_rdata=0x0000_00FF, rsp_resp=0.
REQ-036 Slave returns RRESP=2'b10 with rsp_ready low 5 cycles -> rsp_valid held, rsp_resp=2'b10 stable, cmd_ready=0 throughout.
REQ-037 Reset asserted while in WR_RESP -> next cycle all VALID/READY and rsp_valid 0, cmd_ready=1 after release.
REQ-038 Back-to-back commands, cmd_valid held high -> second accepted only the cycle after rsp handshake.
